// File: rtl/clk_mux_sel_ctrl.sv
// clk_mux_sel_ctrl: select-side sequencer for a glitch-free clock mux.
// Drives a flop-only select bus and holds it for a settle window per switch.
module clk_mux_sel_ctrl #(
   parameter int NUM_INPUTS        = 2,
   parameter int CntWidth          = 16,
   parameter int RESET_SEL         = 0,
   parameter int POST_RESET_CYCLES = 8,
   localparam int SelWidth         = $clog2(NUM_INPUTS)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [SelWidth-1:0] req_sel_i,
   input  logic [CntWidth-1:0] settle_cycles_i,
   output logic [SelWidth-1:0] async_sel_o,
   output logic [SelWidth-1:0] cur_sel_o,
   output logic                busy_o,
   output logic                done_o,
   output logic                err_o
);
   typedef enum logic [1:0] {INIT, IDLE, SETTLE} state_t;

   localparam logic [SelWidth:0] NumIn = (SelWidth + 1)'(NUM_INPUTS);

   state_t              state, state_d;
   logic [CntWidth-1:0] cnt, cnt_d;
   logic [SelWidth-1:0] sel_q, sel_d;
   logic                done_d, err_d, accept, bad_sel;

   assign req_ready_o = state == IDLE;
   assign busy_o      = state != IDLE;
   assign accept      = req_valid_i & req_ready_o;
   assign bad_sel     = {1'b0, req_sel_i} >= NumIn;
   // The mux select input is asynchronous, so no logic may sit after these flops.
   assign async_sel_o = sel_q;
   assign cur_sel_o   = sel_q;

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      sel_d   = sel_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state)
         INIT: begin
            cnt_d   = cnt == '0 ? '0 : cnt - 1'b1;
            state_d = cnt <= CntWidth'(1) ? IDLE : INIT;
         end
         IDLE: begin
            if (accept) begin
               if (bad_sel) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else if (req_sel_i == sel_q) begin
                  done_d = 1'b1;
               end else begin
                  sel_d   = req_sel_i;
                  cnt_d   = settle_cycles_i == '0 ? CntWidth'(1) : settle_cycles_i;
                  state_d = SETTLE;
               end
            end
         end
         SETTLE: begin
            cnt_d   = cnt - 1'b1;
            state_d = cnt <= CntWidth'(1) ? IDLE : SETTLE;
            done_d  = cnt <= CntWidth'(1);
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state  <= INIT;
         cnt    <= CntWidth'(POST_RESET_CYCLES);
         sel_q  <= SelWidth'(RESET_SEL);
         done_o <= 1'b0;
         err_o  <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         sel_q  <= sel_d;
         done_o <= done_d;
         err_o  <= err_d;
      end
   end
endmodule

// File: tb/tb_clk_mux_sel_ctrl.sv
// tb_clk_mux_sel_ctrl: scoreboard bench for clk_mux_sel_ctrl.
// Expected completions are queued on accept and popped when done_o appears.
module tb_clk_mux_sel_ctrl;
   localparam int NI = 3;
   localparam int CW = 16;
   localparam int RS = 0;
   localparam int PR = 8;
   localparam int SW = $clog2(NI);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [SW-1:0] req_sel;
   logic [CW-1:0] settle;
   logic [SW-1:0] async_sel, cur_sel;
   logic          busy, done, err;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   clk_mux_sel_ctrl #(
      .NUM_INPUTS(NI), .CntWidth(CW), .RESET_SEL(RS), .POST_RESET_CYCLES(PR)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_sel_i(req_sel), .settle_cycles_i(settle), .async_sel_o(async_sel),
      .cur_sel_o(cur_sel), .busy_o(busy), .done_o(done), .err_o(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
      end
   endtask

   typedef struct { int d; bit e; } exp_t;
   exp_t q[$];
   int   msel     = RS;
   int   ready_at = 0;

   // Reference model: a request completes a fixed number of cycles after its accept
   // edge; a real switch changes the select at the accept edge and blocks new requests
   // until completion. Inputs change at posedge+2, so the negedge view is stable.
   always @(negedge clk) begin
      bit   exp_rdy;
      int   a, n;
      exp_t e;
      if (!rst_n) begin
         q.delete();
         msel     = RS;
         ready_at = cyc + 1 + PR;
         chk("rst_sel", async_sel, RS);
         chk("rst_ready", req_ready, 0);
         chk("rst_busy", busy, 1);
         chk("rst_done", done, 0);
         chk("rst_err", err, 0);
      end else begin
         exp_rdy = cyc >= ready_at;
         chk("ready", req_ready, exp_rdy);
         chk("busy", busy, !exp_rdy);
         chk("sel", async_sel, msel);
         chk("cur_sel", cur_sel, msel);
         if (done) begin
            chk("done_pending", q.size() > 0, 1);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("done_cycle", cyc, e.d);
               chk("err", err, e.e);
            end
         end else begin
            chk("err_idle", err, 0);
            chk("done_late", q.size() > 0 && q[0].d < cyc, 0);
            if (q.size() > 0 && q[0].d < cyc) void'(q.pop_front());
         end
         if (req_valid && exp_rdy) begin
            a = cyc + 1;
            if (int'(req_sel) >= NI) q.push_back('{a, 1'b1});
            else if (int'(req_sel) == msel) q.push_back('{a, 1'b0});
            else begin
               n = settle == 0 ? 1 : int'(settle);
               q.push_back('{a + n, 1'b0});
               ready_at = a + n;
               msel     = int'(req_sel);
            end
         end
      end
   end

   task automatic send(input int s, input int n);
      bit got = 0;
      req_valid = 1'b1;
      req_sel   = SW'(s);
      settle    = CW'(n);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req_ready) begin
            got = 1;
            break;
         end
      end
      chk("accept", got, 1);
      @(posedge clk);
      #2;
      req_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_sel   = '0;
      settle    = '0;
      repeat (3) @(posedge clk);
      #2;
      req_valid = 1'b1;
      req_sel   = 2;
      settle    = 5;
      rst_n     = 1'b1;
      send(2, 5);
      send(2, 3);
      send(3, 4);
      send(1, 0);
      send(0, 0);
      send(2, 10);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst", async_sel, RS);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (150) begin
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk);
            #2;
            req_valid = 1'b0;
            req_sel   = SW'($urandom);
            settle    = CW'($urandom);
         end
         send($urandom_range(0, 3), $urandom_range(0, 6));
      end
      repeat (20) @(posedge clk);
      chk("drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
